// File: rtl/pc_unit.sv
// pc_unit: program counter for the head of the MIPS fetch stage.
//
// Each cycle the PC takes at most one of, highest priority first: exception,
// stall, eret, ret, ld, br, jmp, inc, hold. call qualifies ld/br/jmp and
// pushes the return address (pc_plus) onto a small circular return-address
// stack (RAS). A ret pops the RAS. If the RAS is empty, ret falls back to
// pc_in and sets a sticky underflow flag.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous, active-high
//   stall      freeze PC, EPC and RAS (exc still wins)
//   inc        sequential advance by STEP
//   ld         load pc_in
//   pc_in      register target / empty-RAS return target
//   br, br_off taken branch, signed word offset relative to pc_plus
//   jmp, jmp_tgt  pseudo-direct jump
//   call       push pc_plus when ld/br/jmp is the selected command
//   ret        return via RAS
//   exc, eret  exception entry / return
//   pc_out     current PC
//   pc_plus    pc_out + STEP (combinational)
//   epc        captured exception PC
//   in_exc     exception mode flag
//   ras_empty, ras_full  registered RAS occupancy views
//   ras_ovf, ras_unf     sticky overflow / underflow flags
module pc_unit #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VEC = '0,
   parameter logic [31:0]      EXC_VEC   = 32'h0000_0180,
   parameter int               STEP      = 4,
   parameter int               RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              inc,
   input  logic              ld,
   input  logic [WIDTH-1:0]  pc_in,
   input  logic              br,
   input  logic [15:0]       br_off,
   input  logic              jmp,
   input  logic [25:0]       jmp_tgt,
   input  logic              call,
   input  logic              ret,
   input  logic              exc,
   input  logic              eret,
   output logic [WIDTH-1:0]  pc_out,
   output logic [WIDTH-1:0]  pc_plus,
   output logic [WIDTH-1:0]  epc,
   output logic              in_exc,
   output logic              ras_empty,
   output logic              ras_full,
   output logic              ras_ovf,
   output logic              ras_unf
);

   localparam int              PTR_W   = $clog2(RAS_DEPTH);
   localparam int              CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);
   localparam logic [WIDTH-1:0] EXC_PC  = WIDTH'(EXC_VEC);
   localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);

   // Byte displacement of a taken branch: signed word offset scaled by 4.
   function automatic logic signed [WIDTH-1:0] br_disp(input logic signed [15:0] off);
      logic signed [WIDTH-1:0] ext;
      ext = WIDTH'(off);
      return ext <<< 2;
   endfunction

   logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0] ras_ptr;   // next write slot; top of stack is ras_ptr-1
   logic [CNT_W-1:0] ras_cnt;

   logic [WIDTH-1:0] pc_next;
   logic [WIDTH-1:0] epc_next;
   logic             in_exc_next;
   logic             push;
   logic             pop;
   logic             unf_set;
   logic [PTR_W-1:0] ptr_next;
   logic [CNT_W-1:0] cnt_next;
   logic [PTR_W-1:0] top_idx;
   logic             cnt_full;

   assign pc_plus  = pc_out + STEP_W;
   assign top_idx  = ras_ptr - PTR_W'(1);
   assign cnt_full = (ras_cnt == CNT_MAX);

   // Command selection
   always_comb begin
      pc_next     = pc_out;
      epc_next    = epc;
      in_exc_next = in_exc;
      push        = 1'b0;
      pop         = 1'b0;
      unf_set     = 1'b0;
      if (exc) begin
         pc_next     = EXC_PC;
         epc_next    = pc_out;
         in_exc_next = 1'b1;
      end else if (!stall) begin
         if (eret) begin
            pc_next     = epc;
            in_exc_next = 1'b0;
         end else if (ret) begin
            if (ras_cnt != '0) begin
               pc_next = ras_mem[top_idx];
               pop     = 1'b1;
            end else begin
               pc_next = pc_in;
               unf_set = 1'b1;
            end
         end else if (ld) begin
            pc_next = pc_in;
            push    = call;
         end else if (br) begin
            pc_next = pc_plus + br_disp(br_off);
            push    = call;
         end else if (jmp) begin
            pc_next = {pc_plus[WIDTH-1:28], jmp_tgt, 2'b00};
            push    = call;
         end else if (inc) begin
            pc_next = pc_plus;
         end
      end
   end

   // RAS pointer/count update; a push while full overwrites the oldest slot
   always_comb begin
      ptr_next = ras_ptr;
      cnt_next = ras_cnt;
      if (push) begin
         ptr_next = ras_ptr + PTR_W'(1);
         if (!cnt_full)
            cnt_next = ras_cnt + CNT_W'(1);
      end else if (pop) begin
         ptr_next = top_idx;
         cnt_next = ras_cnt - CNT_W'(1);
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_out    <= RESET_VEC;
         epc       <= '0;
         in_exc    <= 1'b0;
         ras_ptr   <= '0;
         ras_cnt   <= '0;
         ras_empty <= 1'b1;
         ras_full  <= 1'b0;
         ras_ovf   <= 1'b0;
         ras_unf   <= 1'b0;
      end else begin
         pc_out    <= pc_next;
         epc       <= epc_next;
         in_exc    <= in_exc_next;
         ras_ptr   <= ptr_next;
         ras_cnt   <= cnt_next;
         ras_empty <= (cnt_next == '0);
         ras_full  <= (cnt_next == CNT_MAX);
         if (push && cnt_full)
            ras_ovf <= 1'b1;
         if (unf_set)
            ras_unf <= 1'b1;
      end
   end

   // RAS storage carries data only, so it is not reset
   always_ff @(posedge clk) begin
      if (push)
         ras_mem[ras_ptr] <= pc_plus;
   end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;
   localparam int W     = 32;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          stall, inc, ld, br, jmp, call, ret, exc, eret;
   logic [W-1:0]  pc_in;
   logic [15:0]   br_off;
   logic [25:0]   jmp_tgt;
   logic [W-1:0]  pc_out, pc_plus, epc;
   logic          in_exc, ras_empty, ras_full, ras_ovf, ras_unf;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [W-1:0] m_pc, m_epc;
   logic         m_exc, m_ovf, m_unf;
   logic [W-1:0] m_ras[$];

   pc_unit #(
      .WIDTH(W), .RESET_VEC(32'h0), .EXC_VEC(32'h0000_0180), .STEP(4), .RAS_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .stall(stall), .inc(inc), .ld(ld), .pc_in(pc_in),
      .br(br), .br_off(br_off), .jmp(jmp), .jmp_tgt(jmp_tgt), .call(call), .ret(ret),
      .exc(exc), .eret(eret), .pc_out(pc_out), .pc_plus(pc_plus), .epc(epc),
      .in_exc(in_exc), .ras_empty(ras_empty), .ras_full(ras_full),
      .ras_ovf(ras_ovf), .ras_unf(ras_unf)
   );

   always #5 clk = ~clk;

   task automatic idle();
      stall = 0; inc = 0; ld = 0; br = 0; jmp = 0; call = 0; ret = 0; exc = 0; eret = 0;
      pc_in = '0; br_off = '0; jmp_tgt = '0;
   endtask

   task automatic model_reset();
      m_pc = '0; m_epc = '0; m_exc = 0; m_ovf = 0; m_unf = 0;
      m_ras.delete();
   endtask

   // One cycle of the architectural rules, written from the command priority list
   task automatic model_apply();
      logic [W-1:0] nxt;
      logic         taken;
      nxt   = m_pc + 4;
      taken = 0;
      if (exc) begin
         m_epc = m_pc;
         m_pc  = 32'h180;
         m_exc = 1;
      end else if (!stall) begin
         if (eret) begin
            m_pc  = m_epc;
            m_exc = 0;
         end else if (ret) begin
            if (m_ras.size() > 0) m_pc = m_ras.pop_back();
            else begin m_pc = pc_in; m_unf = 1; end
         end else begin
            if (ld) begin m_pc = pc_in; taken = 1; end
            else if (br) begin m_pc = nxt + 32'(int'($signed(br_off)) * 4); taken = 1; end
            else if (jmp) begin m_pc = (nxt & 32'hF000_0000) + 32'(jmp_tgt) * 4; taken = 1; end
            else if (inc) m_pc = nxt;
            if (taken && call) begin
               if (m_ras.size() == DEPTH) begin
                  void'(m_ras.pop_front());
                  m_ovf = 1;
               end
               m_ras.push_back(nxt);
            end
         end
      end
   endtask

   task automatic step();
      model_apply();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1;
      model_reset();
      #2;
      reset = 0;
   endtask

   task automatic test_reset();
      idle();
      do_reset();
      checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", pc_out, 32'h0); end
      checks++; if (epc !== 32'h0) begin errors++; $display("FAIL reset_epc got %h want %h", epc, 32'h0); end
      checks++; if (in_exc !== 1'b0) begin errors++; $display("FAIL reset_in_exc got %b want 0", in_exc); end
      checks++; if ({ras_empty, ras_full, ras_ovf, ras_unf} !== 4'b1000)
         begin errors++; $display("FAIL reset_flags got %b want 1000", {ras_empty, ras_full, ras_ovf, ras_unf}); end
      checks++; if (pc_plus !== 32'h4) begin errors++; $display("FAIL reset_pc_plus got %h want %h", pc_plus, 32'h4); end
   endtask

   task automatic test_inc();
      logic [W-1:0] exp_pc [3] = '{32'h4, 32'h8, 32'hC};
      idle();
      inc = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (pc_out !== exp_pc[i])
            begin errors++; $display("FAIL inc_%0d got %h want %h", i, pc_out, exp_pc[i]); end
      end
      // asynchronous reset between edges
      reset = 1;
      model_reset();
      #1;
      checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL async_reset got %h want %h", pc_out, 32'h0); end
      reset = 0;
      idle();
      step();
      checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL post_reset_hold got %h want %h", pc_out, 32'h0); end
   endtask

   task automatic test_wrap();
      idle(); ld = 1; pc_in = 32'hFFFF_FFFC; step();
      idle(); inc = 1; step();
      checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL wrap got %h want %h", pc_out, 32'h0); end
   endtask

   task automatic test_branch_jump();
      idle(); ld = 1; pc_in = 32'h100; step();
      idle(); br = 1; br_off = 16'hFFFF; step();
      checks++; if (pc_out !== 32'h100) begin errors++; $display("FAIL br_neg got %h want %h", pc_out, 32'h100); end
      idle(); br = 1; br_off = 16'h0010; inc = 1; step();
      checks++; if (pc_out !== 32'h144) begin errors++; $display("FAIL br_pos got %h want %h", pc_out, 32'h144); end
      idle(); ld = 1; pc_in = 32'h4000_0010; step();
      idle(); jmp = 1; jmp_tgt = 26'h0000040; step();
      checks++; if (pc_out !== 32'h4000_0100) begin errors++; $display("FAIL jmp got %h want %h", pc_out, 32'h4000_0100); end
      // misaligned load passes through; stall holds
      idle(); ld = 1; pc_in = 32'h0000_0123; step();
      checks++; if (pc_out !== 32'h123) begin errors++; $display("FAIL ld_misaligned got %h want %h", pc_out, 32'h123); end
      idle(); stall = 1; inc = 1; ld = 1; pc_in = 32'h500; step();
      checks++; if (pc_out !== 32'h123) begin errors++; $display("FAIL stall_hold got %h want %h", pc_out, 32'h123); end
   endtask

   task automatic test_ras();
      logic [W-1:0] exp_ret [4] = '{32'h54, 32'h44, 32'h34, 32'h24};
      idle(); do_reset();
      for (int i = 1; i <= 5; i++) begin
         idle(); ld = 1; pc_in = 32'(i * 16); step();
         idle(); call = 1; jmp = 1; jmp_tgt = 26'h100; step();
         if (i == 4) begin
            checks++; if (ras_full !== 1'b1 || ras_ovf !== 1'b0)
               begin errors++; $display("FAIL ras_full4 got full=%b ovf=%b want full=1 ovf=0", ras_full, ras_ovf); end
         end
      end
      checks++; if (ras_ovf !== 1'b1) begin errors++; $display("FAIL ras_ovf got %b want 1", ras_ovf); end
      checks++; if (pc_out !== 32'h400) begin errors++; $display("FAIL call_jmp got %h want %h", pc_out, 32'h400); end
      for (int i = 0; i < 4; i++) begin
         idle(); ret = 1; pc_in = 32'h777; step();
         checks++; if (pc_out !== exp_ret[i])
            begin errors++; $display("FAIL ret_%0d got %h want %h", i, pc_out, exp_ret[i]); end
      end
      checks++; if (ras_empty !== 1'b1 || ras_unf !== 1'b0)
         begin errors++; $display("FAIL ras_drained got empty=%b unf=%b want empty=1 unf=0", ras_empty, ras_unf); end
      // ret with call: ret wins, no push
      idle(); ret = 1; call = 1; ld = 1; pc_in = 32'h900; step();
      checks++; if (pc_out !== 32'h900 || ras_unf !== 1'b1)
         begin errors++; $display("FAIL ret_empty got pc=%h unf=%b want pc=900 unf=1", pc_out, ras_unf); end
      checks++; if (ras_empty !== 1'b1)
         begin errors++; $display("FAIL ret_call_nopush got empty=%b want 1", ras_empty); end
   endtask

   task automatic test_exc();
      idle(); do_reset();
      ld = 1; pc_in = 32'h200; step();
      idle(); stall = 1; exc = 1; step();
      checks++; if (pc_out !== 32'h180 || epc !== 32'h200 || in_exc !== 1'b1)
         begin errors++; $display("FAIL exc got pc=%h epc=%h in_exc=%b want 180 200 1", pc_out, epc, in_exc); end
      idle(); eret = 1; step();
      checks++; if (pc_out !== 32'h200 || in_exc !== 1'b0)
         begin errors++; $display("FAIL eret got pc=%h in_exc=%b want 200 0", pc_out, in_exc); end
   endtask

   task automatic test_random();
      idle(); do_reset();
      for (int n = 0; n < 600; n++) begin
         exc     = ($urandom_range(0, 29) == 0);
         stall   = ($urandom_range(0, 7) == 0);
         eret    = ($urandom_range(0, 11) == 0);
         ret     = ($urandom_range(0, 5) == 0);
         ld      = ($urandom_range(0, 4) == 0);
         br      = ($urandom_range(0, 4) == 0);
         jmp     = ($urandom_range(0, 4) == 0);
         inc     = $urandom_range(0, 1);
         call    = ($urandom_range(0, 2) == 0);
         pc_in   = $urandom;
         br_off  = 16'($urandom);
         jmp_tgt = 26'($urandom);
         step();
         checks++;
         if (pc_out !== m_pc || pc_plus !== m_pc + 32'd4 || epc !== m_epc || in_exc !== m_exc ||
             ras_empty !== (m_ras.size() == 0) || ras_full !== (m_ras.size() == DEPTH) ||
             ras_ovf !== m_ovf || ras_unf !== m_unf) begin
            errors++;
            $display("FAIL rand_%0d got pc=%h epc=%h x=%b e=%b f=%b o=%b u=%b want pc=%h epc=%h x=%b n=%0d o=%b u=%b",
                     n, pc_out, epc, in_exc, ras_empty, ras_full, ras_ovf, ras_unf,
                     m_pc, m_epc, m_exc, m_ras.size(), m_ovf, m_unf);
         end
      end
   endtask

   initial begin
      reset = 0;
      idle();
      test_reset();
      test_inc();
      test_wrap();
      test_branch_jump();
      test_ras();
      test_exc();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
